// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle unsigned shift-add multiplier / restoring divider
//            that writes its two-word result through the register file port.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 8,
    parameter int ADR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [ADR_W-1:0] dst_adr,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             reg_write_en,
    output logic [ADR_W-1:0] reg_write_adr,
    output logic [WIDTH-1:0] reg_write_data
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [ADR_W-1:0]   dst_q, dst_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            dst_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc low half shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the true difference is below the divisor, so the low bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        dst_d   = dst_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    dst_d = dst_adr;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    if (op && (op_b == '0)) begin
                        dbz_d   = 1'b1;
                        opnd_d  = op_b;
                        acc_d   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                        rem_d   = op_a;
                        state_d = S_WB_LO;
                    end else begin
                        opnd_d  = op ? op_b : op_a;
                        acc_d   = {{WIDTH{1'b0}}, (op ? op_a : op_b)};
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q) begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_WB_LO;
                end
            end
            S_WB_LO: state_d = S_WB_HI;
            S_WB_HI: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        div_by_zero    = dbz_q;
        reg_write_en   = 1'b0;
        reg_write_adr  = '0;
        reg_write_data = '0;
        case (state_q)
            S_WB_LO: begin
                reg_write_en   = 1'b1;
                reg_write_adr  = dst_q;
                reg_write_data = acc_q[WIDTH-1:0];
            end
            S_WB_HI: begin
                reg_write_en   = 1'b1;
                reg_write_adr  = dst_q + ADR_W'(1);
                reg_write_data = op_q ? rem_q : acc_q[2*WIDTH-1:WIDTH];
                done           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic       op;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] dst_adr;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       reg_write_en;
    logic [3:0] reg_write_adr;
    logic [7:0] reg_write_data;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_op for the calling test to compare.
    int         r_done_cyc, r_busy_cnt, r_nwr, r_wcyc0, r_done_cnt, r_idle_bad;
    logic [3:0] r_adr0, r_adr1;
    logic [7:0] r_d0, r_d1;
    logic       r_dbz1, r_dbz_end;

    muldiv_unit #(.WIDTH(8), .ADR_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .op_a           (op_a),
        .op_b           (op_b),
        .dst_adr        (dst_adr),
        .busy           (busy),
        .done           (done),
        .div_by_zero    (div_by_zero),
        .reg_write_en   (reg_write_en),
        .reg_write_adr  (reg_write_adr),
        .reg_write_data (reg_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, scrambles the operand inputs afterwards, and records
    // what happens for up to 20 cycles. inj_kind 1 = extra start, 2 = rst.
    task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] d, input int inj_cyc, input int inj_kind);
        r_done_cyc = 0; r_busy_cnt = 0; r_nwr = 0; r_wcyc0 = 0; r_done_cnt = 0; r_idle_bad = 0;
        r_adr0 = '0; r_adr1 = '0; r_d0 = '0; r_d1 = '0; r_dbz1 = 1'b0; r_dbz_end = 1'b0;
        op = o; op_a = a; op_b = b; dst_adr = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; op_a = 8'hA5; op_b = 8'h3C; dst_adr = 4'h9;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) r_dbz1 = div_by_zero;
            if (busy === 1'b1) r_busy_cnt++;
            if (reg_write_en === 1'b1) begin
                if (r_nwr == 0) begin
                    r_adr0 = reg_write_adr; r_d0 = reg_write_data; r_wcyc0 = k;
                end else if (r_nwr == 1) begin
                    r_adr1 = reg_write_adr; r_d1 = reg_write_data;
                end
                r_nwr++;
            end else if (reg_write_adr !== 4'h0 || reg_write_data !== 8'h00) begin
                r_idle_bad++;
            end
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = k;
            end
            if (k == inj_cyc) begin
                if (inj_kind == 1) begin
                    start = 1'b1; op = 1'b1; op_a = 8'h77; op_b = 8'h00; dst_adr = 4'h1;
                end else if (inj_kind == 2) begin
                    rst = 1'b1;
                end
            end else if (k == inj_cyc + 1) begin
                start = 1'b0; rst = 1'b0;
            end
            if (done === 1'b1) break;
            @(posedge clk); #1;
        end
        r_dbz_end = div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; op_a = 8'h00; op_b = 8'h00; dst_adr = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        checks++; if ({reg_write_en, reg_write_adr, reg_write_data} !== 13'h0) begin errors++; $display("FAIL reset_wport got %b/%h/%h want 0/0/00", reg_write_en, reg_write_adr, reg_write_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got %b want 0", busy); end
    endtask

    task automatic test_multiply();
        run_op(1'b0, 8'd13, 8'd11, 4'd3, 0, 0);
        checks++; if (r_done_cyc != 10) begin errors++; $display("FAIL mul13_done_cycle got %0d want 10", r_done_cyc); end
        checks++; if (r_busy_cnt != 10) begin errors++; $display("FAIL mul13_busy_cycles got %0d want 10", r_busy_cnt); end
        checks++; if (r_nwr != 2 || r_wcyc0 != 9) begin errors++; $display("FAIL mul13_writes got n=%0d c=%0d want n=2 c=9", r_nwr, r_wcyc0); end
        checks++; if (r_adr0 !== 4'd3 || r_d0 !== 8'h8F) begin errors++; $display("FAIL mul13_lo got %h:%h want 3:8f", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'd4 || r_d1 !== 8'h00) begin errors++; $display("FAIL mul13_hi got %h:%h want 4:00", r_adr1, r_d1); end
        checks++; if (r_dbz_end !== 1'b0 || r_idle_bad != 0 || r_done_cnt != 1) begin errors++; $display("FAIL mul13_misc got dbz=%b idle=%0d dn=%0d want 0/0/1", r_dbz_end, r_idle_bad, r_done_cnt); end
        run_op(1'b0, 8'd255, 8'd255, 4'd6, 0, 0);
        checks++; if (r_adr0 !== 4'd6 || r_d0 !== 8'h01) begin errors++; $display("FAIL mul255_lo got %h:%h want 6:01", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'd7 || r_d1 !== 8'hFE) begin errors++; $display("FAIL mul255_hi got %h:%h want 7:fe", r_adr1, r_d1); end
        checks++; if (r_done_cyc != 10) begin errors++; $display("FAIL mul255_done_cycle got %0d want 10", r_done_cyc); end
    endtask

    task automatic test_divide();
        run_op(1'b1, 8'd200, 8'd7, 4'd15, 0, 0);
        checks++; if (r_adr0 !== 4'hF || r_d0 !== 8'h1C) begin errors++; $display("FAIL div200_lo got %h:%h want f:1c", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'h0 || r_d1 !== 8'h04) begin errors++; $display("FAIL div200_hi_wrap got %h:%h want 0:04", r_adr1, r_d1); end
        checks++; if (r_done_cyc != 10 || r_busy_cnt != 10) begin errors++; $display("FAIL div200_timing got done=%0d busy=%0d want 10/10", r_done_cyc, r_busy_cnt); end
        checks++; if (r_dbz_end !== 1'b0) begin errors++; $display("FAIL div200_dbz got %b want 0", r_dbz_end); end
    endtask

    task automatic test_div_by_zero();
        run_op(1'b1, 8'h55, 8'h00, 4'd2, 0, 0);
        checks++; if (r_done_cyc != 2 || r_wcyc0 != 1 || r_busy_cnt != 2) begin errors++; $display("FAIL dbz_timing got done=%0d wr=%0d busy=%0d want 2/1/2", r_done_cyc, r_wcyc0, r_busy_cnt); end
        checks++; if (r_adr0 !== 4'd2 || r_d0 !== 8'hFF) begin errors++; $display("FAIL dbz_lo got %h:%h want 2:ff", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'd3 || r_d1 !== 8'h55) begin errors++; $display("FAIL dbz_hi got %h:%h want 3:55", r_adr1, r_d1); end
        checks++; if (r_dbz1 !== 1'b1 || r_dbz_end !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b/%b want 1/1", r_dbz1, r_dbz_end); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_sticky got %b want 1", div_by_zero); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 8'h0F, 8'h11, 4'd5, 3, 1);
        checks++; if (r_dbz1 !== 1'b0) begin errors++; $display("FAIL dbz_cleared_by_start got %b want 0", r_dbz1); end
        checks++; if (r_adr0 !== 4'd5 || r_d0 !== 8'hFF) begin errors++; $display("FAIL ignore_lo got %h:%h want 5:ff", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'd6 || r_d1 !== 8'h00) begin errors++; $display("FAIL ignore_hi got %h:%h want 6:00", r_adr1, r_d1); end
        checks++; if (r_done_cyc != 10 || r_dbz_end !== 1'b0) begin errors++; $display("FAIL ignore_misc got done=%0d dbz=%b want 10/0", r_done_cyc, r_dbz_end); end
        run_op(1'b1, 8'd100, 8'd9, 4'd8, 0, 0);
        checks++; if (r_adr0 !== 4'd8 || r_d0 !== 8'h0B) begin errors++; $display("FAIL b2b_lo got %h:%h want 8:0b", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'd9 || r_d1 !== 8'h01) begin errors++; $display("FAIL b2b_hi got %h:%h want 9:01", r_adr1, r_d1); end
        checks++; if (r_done_cyc != 10) begin errors++; $display("FAIL b2b_done_cycle got %0d want 10", r_done_cyc); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_queued_request got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        run_op(1'b0, 8'd200, 8'd200, 4'd4, 5, 2);
        checks++; if (r_busy_cnt != 5) begin errors++; $display("FAIL rst_busy_cycles got %0d want 5", r_busy_cnt); end
        checks++; if (r_nwr != 0 || r_done_cnt != 0) begin errors++; $display("FAIL rst_no_wb got writes=%0d done=%0d want 0/0", r_nwr, r_done_cnt); end
        checks++; if (r_idle_bad != 0 || r_dbz_end !== 1'b0) begin errors++; $display("FAIL rst_outputs got idle=%0d dbz=%b want 0/0", r_idle_bad, r_dbz_end); end
        run_op(1'b1, 8'd9, 8'd2, 4'd10, 0, 0);
        checks++; if (r_adr0 !== 4'hA || r_d0 !== 8'h04) begin errors++; $display("FAIL post_rst_lo got %h:%h want a:04", r_adr0, r_d0); end
        checks++; if (r_adr1 !== 4'hB || r_d1 !== 8'h01) begin errors++; $display("FAIL post_rst_hi got %h:%h want b:01", r_adr1, r_d1); end
        checks++; if (r_done_cyc != 10) begin errors++; $display("FAIL post_rst_done_cycle got %0d want 10", r_done_cyc); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide unit placed beside the single-cycle datapath.
- Consumes the two register read operands (readData1/readData2) and an instruction destination field.
- Produces a two-byte result and writes it back through the register file write port (write enable, 4-bit address, 8-bit data) over two consecutive cycles.
- Control holds the pipeline while busy is high.

Parameters:
- WIDTH, 8, operand and register data width; iteration count equals WIDTH.
- ADR_W, 4, register address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = unsigned multiply, 1 = unsigned divide
- op_a  input  WIDTH  multiplicand / dividend
- op_b  input  WIDTH  multiplier / divisor
- dst_adr  input  ADR_W  destination register for the low result
- busy  output  1  high from the cycle after start is accepted until the operation finishes
- done  output  1  one-cycle pulse in the final writeback cycle
- div_by_zero  output  1  sticky flag for the last operation
- reg_write_en  output  1  register file write enable
- reg_write_adr  output  ADR_W  register file write address
- reg_write_data  output  WIDTH  register file write data

Behaviour:
- Reset is synchronous and active-high; clk is the single clock.
- Reset values: all outputs 0, FSM in IDLE, all internal registers 0.
- States: IDLE, CALC, WB_LO, WB_HI.

IDLE:
- start=1 latches op, op_a, op_b and dst_adr, and clears div_by_zero.
- Normal case: next state CALC with iteration counter = 0.
- op=1 and op_b=0: set div_by_zero=1, quotient = all ones (0xFF), remainder = op_a, next state WB_LO (CALC is skipped).
- start=0: remain in IDLE.

CALC:
- Processes one bit per cycle for exactly WIDTH cycles, then goes to WB_LO.
- Multiply: shift-add on a 2*WIDTH accumulator. Result = full 16-bit product with no overflow loss.
- Divide: restoring division, WIDTH+1-bit partial remainder. Yields quotient and remainder.

WB_LO (one cycle):
- reg_write_en=1, reg_write_adr=dst_adr.
- reg_write_data = product[7:0] for multiply, quotient for divide.
- Next state WB_HI.

WB_HI (one cycle):
- reg_write_en=1, reg_write_adr = dst_adr+1 modulo 2^ADR_W (15 wraps to 0).
- reg_write_data = product[15:8] for multiply, remainder for divide.
- done=1. Next state IDLE.

Outputs and timing:
- busy = 1 in CALC, WB_LO and WB_HI; 0 in IDLE.
- reg_write_en = 0 in IDLE and CALC. reg_write_adr and reg_write_data read 0 whenever reg_write_en=0.
- Latency, start edge to done: WIDTH+2 cycles normally (10 for WIDTH=8); 2 cycles for divide-by-zero.
- A new start is accepted in the cycle after done (back-to-back allowed).
- start while busy: ignored. The latched operands are unaffected and no request is queued.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- div_by_zero holds its value until the next accepted start or rst.
- rst mid-operation (any state): next edge returns to IDLE, all outputs 0, no further writes. A pending writeback is dropped.
- Writes to register 0 are still issued; the register file masks them.

Test Plan:
- Multiply 13*11, dst=3 -> WB_LO writes 0x8F to reg 3, WB_HI writes 0x00 to reg 4. done on the 10th cycle after the start edge, busy high for exactly 10 cycles, div_by_zero=0.
- Multiply 255*255, dst=6 -> writes 0x01 to reg 6, then 0xFE to reg 7.
- Divide 200/7, dst=15 -> writes 0x1C (quotient 28) to reg 15, then 0x04 (remainder 4) to reg 0 (address wrap). done on cycle 10.
- Divide 0x55/0, dst=2 -> writes 0xFF to reg 2 on the cycle after start and 0x55 to reg 3 on the next cycle, with done. div_by_zero=1 and it stays 1 until the next start.
- Start a multiply, then pulse start with different operands in CALC cycle 3 -> the second request is ignored and results match the first operands only. A start asserted in the cycle after done is accepted.
- Assert rst during CALC cycle 5 -> next edge busy=0, reg_write_en never asserts, done never pulses. A following divide 9/2 then completes normally with 0x04 / 0x01.
